shift_imm_decode_stage: RTL and testbench

SHIFT_IMM_DECODE_STAGE -- requirements
Module: shift_imm_decode_stage

---
 rtl/shift_imm_decode_stage_pkg.sv | 31 +++
 rtl/shift_imm_decode_stage_decode.sv | 72 +++++++
 rtl/shift_imm_decode_stage.sv | 112 +++++++++++
 tb/tb_shift_imm_decode_stage.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_imm_decode_stage_pkg.sv
// Shared definitions for the shift-immediate decode stage:
// shift kinds, opcode constants and the decoded bundle.
package shift_imm_decode_stage_pkg;

  typedef enum logic [1:0] {
    SLL  = 2'd0,
    SRL  = 2'd1,
    SRA  = 2'd2,
    ROTR = 2'd3
  } shift_op_e;

  localparam logic [16:0] OPC_SLLI_W  = 17'h00081;
  localparam logic [16:0] OPC_SRLI_W  = 17'h00089;
  localparam logic [16:0] OPC_SRAI_W  = 17'h00091;
  localparam logic [16:0] OPC_ROTRI_W = 17'h00099;

  localparam logic [15:0] OPC_SLLI_D  = 16'h0041;
  localparam logic [15:0] OPC_SRLI_D  = 16'h0045;
  localparam logic [15:0] OPC_SRAI_D  = 16'h0049;
  localparam logic [15:0] OPC_ROTRI_D = 16'h004D;

  typedef struct packed {
    shift_op_e   op;
    logic        is_d;
    logic        illegal;
    logic [4:0]  rd;
    logic [4:0]  rj;
    logic [5:0]  shamt;
  } dec_t;

endpackage

// File: rtl/shift_imm_decode_stage_decode.sv
// Combinational decoder for the W and D shift-immediate forms.
// D forms are only legal on a 64-bit datapath.
module shift_imm_decode
  import shift_imm_decode_stage_pkg::*;
#(
  parameter int GRLEN = 32
) (
  input  logic [31:0] instr,
  output dec_t        dec
);

  localparam bit HAS_D = (GRLEN == 64);

  logic [16:0] opc_w;
  logic [15:0] opc_d;
  logic        hit_w;
  logic        hit_d;
  shift_op_e   op_w;
  shift_op_e   op_d;

  assign opc_w = instr[31:15];
  assign opc_d = instr[31:16];

  always_comb begin
    hit_w = 1'b1;
    op_w  = SLL;
    case (opc_w)
      OPC_SLLI_W:  op_w = SLL;
      OPC_SRLI_W:  op_w = SRL;
      OPC_SRAI_W:  op_w = SRA;
      OPC_ROTRI_W: op_w = ROTR;
      default:     hit_w = 1'b0;
    endcase
  end

  always_comb begin
    hit_d = HAS_D;
    op_d  = SLL;
    case (opc_d)
      OPC_SLLI_D:  op_d = SLL;
      OPC_SRLI_D:  op_d = SRL;
      OPC_SRAI_D:  op_d = SRA;
      OPC_ROTRI_D: op_d = ROTR;
      default:     hit_d = 1'b0;
    endcase
  end

  // Register fields always pass through, even on illegal words.
  always_comb begin
    dec.op      = SLL;
    dec.is_d    = 1'b0;
    dec.illegal = 1'b1;
    dec.rd      = instr[4:0];
    dec.rj      = instr[9:5];
    dec.shamt   = 6'd0;
    unique case (1'b1)
      hit_w: begin
        dec.op      = op_w;
        dec.illegal = 1'b0;
        dec.shamt   = {1'b0, instr[14:10]};
      end
      hit_d: begin
        dec.op      = op_d;
        dec.is_d    = 1'b1;
        dec.illegal = 1'b0;
        dec.shamt   = instr[15:10];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/shift_imm_decode_stage.sv
// Shift-immediate decode stage: decode on input, then a
// two-entry skid buffer (OUT + SKID) with registered in_ready.
module shift_imm_decode_stage
  import shift_imm_decode_stage_pkg::*;
#(
  parameter int GRLEN = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output shift_op_e        out_op,
  output logic             out_is_d,
  output logic             out_illegal,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rj,
  output logic [5:0]       out_shamt,
  output logic [TAG_W-1:0] out_tag
);

  dec_t in_dec;

  shift_imm_decode #(
    .GRLEN(GRLEN)
  ) u_dec (
    .instr(in_instr),
    .dec  (in_dec)
  );

  logic             out_valid_q, out_valid_d;
  dec_t             out_dec_q, out_dec_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic             skid_valid_q, skid_valid_d;
  dec_t             skid_dec_q, skid_dec_d;
  logic [TAG_W-1:0] skid_tag_q, skid_tag_d;

  logic in_fire;
  logic out_fire;

  assign in_ready = !skid_valid_q;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_dec_d    = out_dec_q;
    out_tag_d    = out_tag_q;
    skid_valid_d = skid_valid_q;
    skid_dec_d   = skid_dec_q;
    skid_tag_d   = skid_tag_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_fire) begin
      // SKID is full only when in_ready is low, so no input here.
      if (skid_valid_q) begin
        out_dec_d    = skid_dec_q;
        out_tag_d    = skid_tag_q;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        out_dec_d = in_dec;
        out_tag_d = in_tag;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      if (out_valid_q) begin
        skid_valid_d = 1'b1;
        skid_dec_d   = in_dec;
        skid_tag_d   = in_tag;
      end else begin
        out_valid_d = 1'b1;
        out_dec_d   = in_dec;
        out_tag_d   = in_tag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_dec_q    <= '0;
      out_tag_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_dec_q   <= '0;
      skid_tag_q   <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_dec_q    <= out_dec_d;
      out_tag_q    <= out_tag_d;
      skid_valid_q <= skid_valid_d;
      skid_dec_q   <= skid_dec_d;
      skid_tag_q   <= skid_tag_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_op      = out_dec_q.op;
  assign out_is_d    = out_dec_q.is_d;
  assign out_illegal = out_dec_q.illegal;
  assign out_rd      = out_dec_q.rd;
  assign out_rj      = out_dec_q.rj;
  assign out_shamt   = out_dec_q.shamt;
  assign out_tag     = out_tag_q;

endmodule

// File: tb/tb_shift_imm_decode_stage.sv
// Bench for shift_imm_decode_stage: 32- and 64-bit instances
// driven in parallel and checked against a queue model.
module tb_shift_imm_decode_stage;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_instr;
  logic [7:0]  in_tag;

  logic       ir32, ov32, d32, il32;
  logic [1:0] op32;
  logic [4:0] rd32, rj32;
  logic [5:0] sh32;
  logic [7:0] tg32;

  logic       ir64, ov64, d64, il64;
  logic [1:0] op64;
  logic [4:0] rd64, rj64;
  logic [5:0] sh64;
  logic [7:0] tg64;

  int checks;
  int failures;

  logic [31:0] mq_i[$];
  logic [7:0]  mq_t[$];
  logic [7:0]  seen[$];
  bit          m_rst;

  localparam logic [31:0] W = 32'h00448C41;

  shift_imm_decode_stage #(.GRLEN(32), .TAG_W(8)) u32 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(ir32),
    .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(ov32), .out_ready(out_ready),
    .out_op(op32), .out_is_d(d32), .out_illegal(il32),
    .out_rd(rd32), .out_rj(rj32), .out_shamt(sh32),
    .out_tag(tg32)
  );

  shift_imm_decode_stage #(.GRLEN(64), .TAG_W(8)) u64 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(ir64),
    .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(ov64), .out_ready(out_ready),
    .out_op(op64), .out_is_d(d64), .out_illegal(il64),
    .out_rd(rd64), .out_rj(rj64), .out_shamt(sh64),
    .out_tag(tg64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", n, a, e);
    end
  endtask

  // Opcode table viewed arithmetically: W opcodes step by 8,
  // D opcodes step by 4, shift kind is the step index.
  // Returns {illegal, is_d, op[1:0], shamt[5:0]}.
  function automatic logic [9:0] mdl(input logic [31:0] w,
                                     input int g);
    logic [16:0] h17;
    logic [15:0] h16;
    logic [9:0]  r;
    h17 = w[31:15];
    h16 = w[31:16];
    r = {1'b1, 1'b0, 2'd0, 6'd0};
    for (int k = 0; k < 4; k++) begin
      if (h17 == 17'(32'h81 + 8 * k))
        r = {1'b0, 1'b0, 2'(k), 1'b0, w[14:10]};
      if (g == 64 && h16 == 16'(32'h41 + 4 * k))
        r = {1'b0, 1'b1, 2'(k), w[15:10]};
    end
    return r;
  endfunction

  function automatic logic [31:0] rnd_word();
    logic [31:0] r;
    int k;
    r = $urandom;
    k = $urandom_range(0, 3);
    case ($urandom_range(0, 2))
      0: r[31:15] = 17'(32'h81 + 8 * k);
      1: r[31:16] = 16'(32'h41 + 4 * k);
      default: ;
    endcase
    return r;
  endfunction

  task automatic cmp(input string s, input int g,
                     input logic ov, input logic ir,
                     input logic [1:0] op, input logic d,
                     input logic il, input logic [4:0] rd,
                     input logic [4:0] rj, input logic [5:0] sh,
                     input logic [7:0] tg);
    logic [9:0] e;
    chk({s, "_valid"}, ov, mq_i.size() > 0);
    chk({s, "_in_ready"}, ir, mq_i.size() < 2);
    if (m_rst) begin
      chk({s, "_rst_fields"}, {op, d, il, rd, rj, sh, tg}, 0);
    end else if (mq_i.size() > 0) begin
      e = mdl(mq_i[0], g);
      chk({s, "_illegal"}, il, e[9]);
      chk({s, "_is_d"}, d, e[8]);
      chk({s, "_op"}, op, e[7:6]);
      chk({s, "_shamt"}, sh, e[5:0]);
      chk({s, "_rd"}, rd, mq_i[0][4:0]);
      chk({s, "_rj"}, rj, mq_i[0][9:5]);
      chk({s, "_tag"}, tg, mq_t[0]);
    end
  endtask

  // Stage modelled as an ordered queue of capacity two.
  always @(posedge clk) begin
    bit inf;
    bit outf;
    inf  = in_valid && (mq_i.size() < 2);
    outf = out_ready && (mq_i.size() > 0);
    if (!rst && !flush && ov32 && out_ready)
      seen.push_back(tg32);
    if (rst || flush) begin
      mq_i.delete();
      mq_t.delete();
    end else begin
      if (outf) begin
        void'(mq_i.pop_front());
        void'(mq_t.pop_front());
      end
      if (inf) begin
        mq_i.push_back(in_instr);
        mq_t.push_back(in_tag);
      end
    end
    m_rst = rst;
    #1;
    cmp("g32", 32, ov32, ir32, op32, d32, il32,
        rd32, rj32, sh32, tg32);
    cmp("g64", 64, ov64, ir64, op64, d64, il64,
        rd64, rj64, sh64, tg64);
  end

  task automatic put(input logic v, input logic [31:0] w,
                     input logic [7:0] t, input logic r);
    in_valid  = v;
    in_instr  = w;
    in_tag    = t;
    out_ready = r;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    flush    = 1'b0;
    put(1'b0, 32'h0, 8'h0, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_valid", ov32, 1'b0);
    chk("rst_in_ready", ir32, 1'b1);
    chk("rst_tag", tg32, 8'h0);

    put(1'b1, 32'h00408C41, 8'h01, 1'b1);
    @(negedge clk);
    chk("slli_w_valid", ov32, 1'b1);
    chk("slli_w_op", op32, 2'd0);
    chk("slli_w_is_d", d32, 1'b0);
    chk("slli_w_rd", rd32, 5'd1);
    chk("slli_w_rj", rj32, 5'd2);
    chk("slli_w_shamt", sh32, 6'd3);
    chk("slli_w_illegal", il32, 1'b0);

    put(1'b1, 32'h0049FC85, 8'h02, 1'b1);
    @(negedge clk);
    chk("srai_d_op", op64, 2'd2);
    chk("srai_d_is_d", d64, 1'b1);
    chk("srai_d_rd", rd64, 5'd5);
    chk("srai_d_rj", rj64, 5'd4);
    chk("srai_d_shamt", sh64, 6'd63);
    chk("srai_d_illegal", il64, 1'b0);
    chk("srai_d_g32_illegal", il32, 1'b1);
    chk("srai_d_g32_shamt", sh32, 6'd0);
    chk("srai_d_g32_op", op32, 2'd0);
    chk("srai_d_g32_rd", rd32, 5'd5);

    put(1'b1, 32'h004CFC00, 8'h03, 1'b1);
    @(negedge clk);
    chk("rotri_w_op", op32, 2'd3);
    chk("rotri_w_shamt", sh32, 6'd31);
    chk("rotri_w_illegal", il32, 1'b0);

    put(1'b1, 32'h00000000, 8'h04, 1'b1);
    @(negedge clk);
    chk("zero_illegal32", il32, 1'b1);
    chk("zero_illegal64", il64, 1'b1);

    for (int i = 0; i < 60; i++) begin
      put(1'($urandom_range(0, 1)), rnd_word(), 8'(20 + i),
          1'($urandom_range(0, 1)));
      @(negedge clk);
    end
    put(1'b0, 32'h0, 8'h0, 1'b1);
    repeat (3) @(negedge clk);

    // Back-to-back with a stalled consumer.
    seen.delete();
    put(1'b1, W, 8'd1, 1'b0);
    @(negedge clk);
    put(1'b1, W, 8'd2, 1'b0);
    @(negedge clk);
    chk("stall_in_ready", ir32, 1'b0);
    chk("stall_tag", tg32, 8'd1);
    put(1'b1, W, 8'd3, 1'b0);
    repeat (2) @(negedge clk);
    chk("stall_hold_tag", tg32, 8'd1);
    chk("stall_hold_valid", ov32, 1'b1);
    out_ready = 1'b1;
    @(negedge clk);
    for (int n = 0; n < 20 && !ir32; n++) @(negedge clk);
    chk("stall_release_ready", ir32, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("order_count", seen.size(), 3);
    if (seen.size() == 3)
      chk("order_tags", {seen[0], seen[1], seen[2]}, 24'h010203);

    // Flush while full, with an input offered.
    seen.delete();
    put(1'b1, W, 8'd10, 1'b0);
    @(negedge clk);
    put(1'b1, W, 8'd11, 1'b0);
    @(negedge clk);
    chk("flush_full", ir32, 1'b0);
    flush = 1'b1;
    put(1'b1, W, 8'd12, 1'b0);
    @(negedge clk);
    flush = 1'b0;
    put(1'b0, 32'h0, 8'h0, 1'b1);
    chk("flush_valid", ov32, 1'b0);
    chk("flush_in_ready", ir32, 1'b1);
    repeat (4) @(negedge clk);
    chk("flush_nothing_out", seen.size(), 0);

    // Reset while full, overriding flush and input.
    put(1'b1, W, 8'd13, 1'b0);
    @(negedge clk);
    put(1'b1, W, 8'd14, 1'b0);
    @(negedge clk);
    chk("rstfull_full", ir32, 1'b0);
    rst   = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    flush = 1'b0;
    put(1'b0, 32'h0, 8'h0, 1'b1);
    chk("rstfull_valid", ov32, 1'b0);
    chk("rstfull_in_ready", ir32, 1'b1);
    chk("rstfull_fields32",
        {op32, d32, il32, rd32, rj32, sh32, tg32}, 0);
    chk("rstfull_fields64",
        {ov64, op64, d64, il64, rd64, rj64, sh64, tg64}, 0);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
